uart_param: RTL and testbench
=============================

# uart_param

Parametrised UART with configurable data width, parity, stop length, baud divisor and FIFO depth. Adds per-word parity/framing error flags and a sticky overrun flag. It keeps the existing `uart` port set (`rd_uart`/`wr_uart`/`rx`/`w_data`/`tx_full`/`rx_empty`/`tx`/`r_data`) as a superset, and replaces `uart` at the top level wherever a non-8N1 link or deeper buffering is needed.

## Interface
- `DBIT`, 8: data bits per frame, 5..9.
- `PAR_EN`, 0: 1 adds a parity bit after the data bits.
- `PAR_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PAR_EN`=0.
- `SB_TICK`, 16: stop length in oversample ticks (16/24/32 = 1/1.5/2 stop bits).
- `DVSR`, 163: clk cycles per oversample tick (baud = f_clk / (16·DVSR)), ≥2.
- `FIFO_W`, 2: FIFO address bits; each FIFO holds 2^FIFO_W words.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rd_uart` in 1: pop the RX FIFO head.
- `wr_uart` in 1: push `w_data` into the TX FIFO.
- `rx` in 1: serial input, asynchronous.
- `w_data` in DBIT: TX word.
- `clr_err` in 1: clears `overrun`.
- `tx_full` out 1: TX FIFO full.
- `rx_empty` out 1: RX FIFO empty.
- `tx` out 1: serial output, idle high.
- `r_data` out DBIT: RX FIFO head.
- `r_perr` out 1: parity error flag of the RX head word.
- `r_ferr` out 1: framing error flag of the RX head word.
- `overrun` out 1: sticky; a received word was dropped.

## Operation
- Reset values: `tx`=1, `tx_full`=0, `rx_empty`=1, `overrun`=0. All FSMs go to IDLE, all counters to 0, both FIFOs empty. Memory contents are not reset; `r_data`, `r_perr` and `r_ferr` are don't-care while `rx_empty`=1.
- Reset applied mid-frame aborts the frame. Both FIFOs are flushed.
- Baud generator: counter 0..DVSR-1; `tick` is a 1-cycle pulse when count = DVSR-1, after which the counter wraps to 0.
- `rx` passes through a 2-flop synchroniser (reset value 1) before the RX FSM.
- RX FSM: IDLE → START → DATA → PARITY (only if `PAR_EN`) → STOP → IDLE.
  - IDLE: a synchronised 0 enters START with the tick count cleared.
  - START: at tick 7 (mid-bit), rx=1 means a glitch and the FSM returns to IDLE; rx=0 goes to DATA.
  - DATA: samples every 16th tick, LSB first, for DBIT bits.
  - PARITY: samples one bit; `perr` is set when the received bit ≠ the computed parity.
  - STOP: at tick SB_TICK-1, sample rx; `ferr` = !rx. The word and both flags are pushed, then return to IDLE.
  - `ferr` does not hold the FSM; a new start bit is hunted from IDLE.
- RX push while the RX FIFO is full drops the word and sets `overrun`. The FIFO is unchanged.
- `overrun` clears on `clr_err`. If a set and a clear coincide, set wins.
- TX FSM: IDLE → START → DATA → PARITY (only if `PAR_EN`) → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty: pop one word into the shift register and enter START.
  - Each bit is held 16 ticks; stop is held SB_TICK ticks.
  - After STOP, if the FIFO is non-empty the next word starts directly with no idle gap.
- FIFOs (first-word-fall-through; head is visible while non-empty):
  - Write when full is ignored; read when empty is ignored.
  - Read and write in the same cycle:
    - Empty: write only.
    - Full: both occur, count unchanged.
    - Otherwise: both occur.
  - Pointers wrap modulo 2^FIFO_W.
  - `full`/`empty` update the cycle after the access.

## Timing
- `wr_uart` at cycle n with the TX FSM idle: pop at n+1; `tx` goes to 0 at n+2. After that, bit edges fall on tick boundaries.
- Frame length on the line: 16·(1+DBIT+PAR_EN)+SB_TICK ticks.
- RX: `rx_empty` falls 2 cycles after the STOP sample tick (push, then flag update).
- `rd_uart` at n: the next head is on `r_data` at n+1.
- The tick counter free-runs and is not realigned to the start bit. RX start-bit detection jitter is ≤1 tick.

## Structure
- `uart_pkg` holds:
  - The shared state enum (IDLE, START, DATA, PARITY, STOP).
  - Function `par_calc(data, odd)` returning the parity bit.
  - Tick constants (16 per bit, mid-bit sample at tick 7).
- Sub-module `uart_fifo` (params `W`, `AW`), instantiated twice:
  - TX FIFO: W=DBIT.
  - RX FIFO: W=DBIT+2, with perr and ferr stored alongside the data.
- The baud generator, RX FSM and TX FSM are inline in `uart_param`.

## Test plan
Benches use DVSR=2, FIFO_W=2 unless noted.
- Loopback `tx`→`rx`, 8N1, write 8'hA7: line shows 0,1,1,1,0,0,1,0,1,1 (start, LSB first, stop), 16 ticks each. RX then delivers `r_data`=A7, `r_perr`=0, `r_ferr`=0.
- PAR_EN=1, PAR_ODD=0: drive 8'h03 on `rx` with parity bit 1 → `r_perr`=1, `r_ferr`=0. Repeat with parity bit 0 → `r_perr`=0.
- Drive 8'h55 with stop bit 0 → `r_ferr`=1. The following valid frame 8'h12 is received cleanly.
- Send 5 frames with `rd_uart`=0:
  - The first 4 words are kept, `overrun`=1, and the 5th word is dropped.
  - `clr_err` → `overrun`=0.
  - Reads then return words 1..4 in order.
- Write 6 words on consecutive cycles: `tx_full`=1 after the 5th (one word already popped). The 6th write is ignored. Exactly 5 frames are transmitted, back-to-back.
- Assert `reset` mid-DATA of a TX frame: `tx`=1 on the next cycle, `tx_full`=0, `rx_empty`=1, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, tick constants and parity helper for uart_param
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int TICKS_PER_BIT = 16;
    localparam int MID_TICK      = 7;

    // Callers zero-extend narrower words; extra zero bits do not change the XOR.
    function automatic logic par_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through FIFO with registered occupancy count
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rd_en;
    logic          wr_en;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= w_data;
    end

    assign r_data = mem[rd_ptr];
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised UART with parity, configurable stop length and error flags
module uart_param
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_uart,
    input  logic            wr_uart,
    input  logic            rx,
    input  logic [DBIT-1:0] w_data,
    input  logic            clr_err,
    output logic            tx_full,
    output logic            rx_empty,
    output logic            tx,
    output logic [DBIT-1:0] r_data,
    output logic            r_perr,
    output logic            r_ferr,
    output logic            overrun
);

    localparam logic [15:0] DVSR_M1 = 16'(DVSR - 1);
    localparam logic [4:0]  T_LAST  = 5'(TICKS_PER_BIT - 1);
    localparam logic [4:0]  T_MID   = 5'(MID_TICK);
    localparam logic [4:0]  T_STOP  = 5'(SB_TICK - 1);
    localparam logic [3:0]  N_LAST  = 4'(DBIT - 1);
    localparam logic        PAR_ON  = (PAR_EN != 0);
    localparam logic        ODD     = (PAR_ODD != 0);

    logic [15:0] baud_cnt;
    logic        tick;
    logic        rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
        end
    end

    assign tick = (baud_cnt == DVSR_M1);

    state_t            rx_state, rx_state_next;
    logic [4:0]        rx_s, rx_s_next;
    logic [3:0]        rx_n, rx_n_next;
    logic [DBIT-1:0]   rx_b, rx_b_next;
    logic              rx_perr, rx_perr_next;
    logic              rx_push, rx_push_q, rx_full;
    logic [DBIT+1:0]   rx_word_q, rx_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state  <= IDLE;
            rx_s      <= '0;
            rx_n      <= '0;
            rx_b      <= '0;
            rx_perr   <= 1'b0;
            rx_push_q <= 1'b0;
            rx_word_q <= '0;
        end else begin
            rx_state  <= rx_state_next;
            rx_s      <= rx_s_next;
            rx_n      <= rx_n_next;
            rx_b      <= rx_b_next;
            rx_perr   <= rx_perr_next;
            rx_push_q <= rx_push;
            if (rx_push) rx_word_q <= {rx_perr, !rx_sync, rx_b};
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_s_next     = rx_s;
        rx_n_next     = rx_n;
        rx_b_next     = rx_b;
        rx_perr_next  = rx_perr;
        case (rx_state)
            IDLE: if (!rx_sync) begin
                rx_state_next = START;
                rx_s_next     = '0;
                rx_perr_next  = 1'b0;
            end
            START: if (tick) begin
                if (rx_s == T_MID) begin
                    rx_state_next = rx_sync ? IDLE : DATA;
                    rx_s_next     = '0;
                    rx_n_next     = '0;
                end else rx_s_next = rx_s + 5'd1;
            end
            DATA: if (tick) begin
                if (rx_s == T_LAST) begin
                    rx_s_next = '0;
                    rx_b_next = {rx_sync, rx_b[DBIT-1:1]};
                    if (rx_n == N_LAST) rx_state_next = PAR_ON ? PARITY : STOP;
                    else                rx_n_next     = rx_n + 4'd1;
                end else rx_s_next = rx_s + 5'd1;
            end
            PARITY: if (tick) begin
                if (rx_s == T_LAST) begin
                    rx_s_next     = '0;
                    rx_perr_next  = (rx_sync != par_calc(9'(rx_b), ODD));
                    rx_state_next = STOP;
                end else rx_s_next = rx_s + 5'd1;
            end
            STOP: if (tick) begin
                if (rx_s == T_STOP) rx_state_next = IDLE;
                else                rx_s_next     = rx_s + 5'd1;
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rx_state == STOP) && tick && (rx_s == T_STOP);
    end

    uart_fifo #(.W(DBIT + 2), .AW(FIFO_W)) rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_push_q),
        .w_data (rx_word_q),
        .r_data (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    assign {r_perr, r_ferr, r_data} = rx_head;

    // A simultaneous read makes room, so only a push into a full, unread FIFO is lost.
    always_ff @(posedge clk) begin
        if (reset)                                      overrun <= 1'b0;
        else if (rx_push_q && rx_full && !rd_uart)      overrun <= 1'b1;
        else if (clr_err)                               overrun <= 1'b0;
    end

    state_t          tx_state, tx_state_next;
    logic [4:0]      tx_s, tx_s_next;
    logic [3:0]      tx_n, tx_n_next;
    logic [DBIT-1:0] tx_b, tx_b_next, tx_head;
    logic            tx_p, tx_p_next;
    logic            tx_reg, tx_next, tx_pop, tx_empty;

    uart_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .r_data (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_p     <= 1'b0;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_s     <= tx_s_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx_p     <= tx_p_next;
            tx_reg   <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_s_next     = tx_s;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        tx_p_next     = tx_p;
        case (tx_state)
            IDLE: ;
            START, PARITY: if (tick) begin
                if (tx_s == T_LAST) begin
                    tx_s_next     = '0;
                    tx_n_next     = '0;
                    tx_state_next = (tx_state == START) ? DATA : STOP;
                end else tx_s_next = tx_s + 5'd1;
            end
            DATA: if (tick) begin
                if (tx_s == T_LAST) begin
                    tx_s_next = '0;
                    tx_b_next = tx_b >> 1;
                    if (tx_n == N_LAST) tx_state_next = PAR_ON ? PARITY : STOP;
                    else                tx_n_next     = tx_n + 4'd1;
                end else tx_s_next = tx_s + 5'd1;
            end
            STOP: if (tick) begin
                if (tx_s == T_STOP) tx_state_next = IDLE;
                else                tx_s_next     = tx_s + 5'd1;
            end
            default: tx_state_next = IDLE;
        endcase
        // Loading from IDLE or at the end of STOP gives back-to-back frames with no idle gap.
        if (tx_pop) begin
            tx_state_next = START;
            tx_s_next     = '0;
            tx_b_next     = tx_head;
            tx_p_next     = par_calc(9'(tx_head), ODD);
        end
    end

    always_comb begin
        tx_pop = !tx_empty &&
                 ((tx_state == IDLE) || ((tx_state == STOP) && tick && (tx_s == T_STOP)));
        case (tx_state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_b_next[0];
            PARITY:  tx_next = tx_p_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - self-checking bench for uart_param: vector table, loopback, overrun, reset
module tb_uart_param;

    localparam int BITC = 32;  // clk cycles per bit at DVSR=2
    localparam int FRAMEC = 10 * BITC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rd0 = 0, wr0 = 0, clr0 = 0, loop = 0, rx_drv0 = 1;
    logic [7:0] w0 = 0;
    logic       rx0, txf0, rxe0, tx0, perr0, ferr0, ovr0;
    logic [7:0] rdat0;
    assign rx0 = loop ? tx0 : rx_drv0;

    logic       rd1 = 0, rx1 = 1;
    logic       txf1, rxe1, tx1, perr1, ferr1, ovr1;
    logic [7:0] rdat1;
    logic [7:0] w1 = 8'h00;
    logic       wr1 = 0, clr1 = 0;

    uart_param #(.DBIT(8), .PAR_EN(0), .PAR_ODD(0), .SB_TICK(16), .DVSR(2), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .rd_uart(rd0), .wr_uart(wr0), .rx(rx0), .w_data(w0),
        .clr_err(clr0), .tx_full(txf0), .rx_empty(rxe0), .tx(tx0), .r_data(rdat0),
        .r_perr(perr0), .r_ferr(ferr0), .overrun(ovr0));

    uart_param #(.DBIT(8), .PAR_EN(1), .PAR_ODD(0), .SB_TICK(16), .DVSR(2), .FIFO_W(2)) dut_p (
        .clk(clk), .reset(reset), .rd_uart(rd1), .wr_uart(wr1), .rx(rx1), .w_data(w1),
        .clr_err(clr1), .tx_full(txf1), .rx_empty(rxe1), .tx(tx1), .r_data(rdat1),
        .r_perr(perr1), .r_ferr(ferr1), .overrun(ovr1));

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       eperr;
        logic       eferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    vec_t vec[8];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_line(input logic sel, input logic val, input int n);
        if (sel) rx1 = val;
        else     rx_drv0 = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input vec_t v);
        set_line(v.sel, 1'b0, BITC);
        for (int i = 0; i < 8; i++) set_line(v.sel, v.data[i], BITC);
        if (v.sel) set_line(v.sel, v.par, BITC);
        if (v.stop) set_line(v.sel, 1'b1, BITC);
        else        set_line(v.sel, 1'b0, 24);
        set_line(v.sel, 1'b1, BITC);
    endtask

    task automatic expect_word(input logic sel, input string tag, input bit chk_empty);
        bit   ok;
        exp_t e;
        ok = 0;
        for (int k = 0; k < 800 && !ok; k++) begin
            if ((sel ? rxe1 : rxe0) == 1'b0) ok = 1;
            else @(negedge clk);
        end
        check($sformatf("%s ready", tag), 32'(ok), 1);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s data", tag), 32'(sel ? rdat1 : rdat0), 32'(e.d));
            check($sformatf("%s perr", tag), 32'(sel ? perr1 : perr0), 32'(e.perr));
            check($sformatf("%s ferr", tag), 32'(sel ? ferr1 : ferr0), 32'(e.ferr));
            if (sel) rd1 = 1; else rd0 = 1;
            @(negedge clk);
            rd0 = 0;
            rd1 = 0;
            if (chk_empty) check($sformatf("%s empty", tag), 32'(sel ? rxe1 : rxe0), 1);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] line_exp;
        logic [7:0] words [6];
        int f, bad;

        vec[0] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[1] = '{1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[3] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[5] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[6] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        line_exp = 10'b1101001110;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;

        repeat (4) @(negedge clk);
        check("reset tx", 32'(tx0), 1);
        check("reset tx_full", 32'(txf0), 0);
        check("reset rx_empty", 32'(rxe0), 1);
        check("reset overrun", 32'(ovr0), 0);
        check("reset tx parity dut", 32'(tx1), 1);
        check("reset txf parity dut", 32'(txf1), 0);
        check("reset ovr parity dut", 32'(ovr1), 0);
        reset = 0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sb.push_back('{vec[i].data, vec[i].eperr, vec[i].eferr});
            drive_frame(vec[i]);
            expect_word(vec[i].sel, $sformatf("vec%0d", i), 1'b1);
        end

        // Loopback of a single word: latency and line shape.
        loop = 1;
        repeat (4) @(negedge clk);
        w0 = 8'hA7;
        wr0 = 1;
        @(negedge clk);
        wr0 = 0;
        check("tx latency n+1", 32'(tx0), 1);
        @(negedge clk);
        check("tx latency n+2", 32'(tx0), 0);
        f = cyc;
        for (int i = 0; i < 10; i++) begin
            wait_until(f + 16 + BITC * i);
            check($sformatf("line bit%0d", i), 32'(tx0), 32'(line_exp[i]));
        end
        sb.push_back('{8'hA7, 1'b0, 1'b0});
        expect_word(1'b0, "loop A7", 1'b1);
        repeat (64) @(negedge clk);

        // Six consecutive writes; fifth fills the FIFO, sixth is dropped.
        wr0 = 1;
        f = cyc + 2;
        for (int i = 0; i < 6; i++) begin
            w0 = words[i];
            if (i == 4) check("tx_full before 5th", 32'(txf0), 0);
            if (i == 5) check("tx_full after 5th", 32'(txf0), 1);
            @(negedge clk);
        end
        wr0 = 0;
        check("tx_full after 6th", 32'(txf0), 1);
        wait_until(f + 4 * FRAMEC + 8);
        check("back-to-back 5th start", 32'(tx0), 0);
        wait_until(f + 5 * FRAMEC + 8);
        bad = 0;
        repeat (400) begin
            if (tx0 !== 1'b1) bad++;
            @(negedge clk);
        end
        check("no 6th frame", 32'(bad), 0);
        check("overrun set", 32'(ovr0), 1);
        clr0 = 1;
        @(negedge clk);
        clr0 = 0;
        check("overrun cleared", 32'(ovr0), 0);
        for (int i = 0; i < 4; i++) sb.push_back('{words[i], 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) expect_word(1'b0, $sformatf("ovr word%0d", i), i == 3);

        // Reset in the middle of a TX data phase flushes everything.
        wr0 = 1;
        for (int i = 0; i < 3; i++) begin
            w0 = words[i];
            @(negedge clk);
        end
        wr0 = 0;
        repeat (100) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid reset tx", 32'(tx0), 1);
        check("mid reset tx_full", 32'(txf0), 0);
        check("mid reset rx_empty", 32'(rxe0), 1);
        bad = 0;
        repeat (2 * FRAMEC) begin
            if (tx0 !== 1'b1) bad++;
            @(negedge clk);
        end
        check("no frame after reset", 32'(bad), 0);
        check("rx still empty after reset", 32'(rxe0), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
